ocp_burst_wr_master: RTL and testbench
======================================

Name: ocp_burst_wr_master

Overview:
- OCP-style burst-write initiator that drives the slave's write-request interface.
- The slave side holds the address counter (clear/increment/load).
- On a one-cycle start, the block latches a base address and burst length. It then pulls words from an upstream valid/ready source and issues them as consecutive write requests at incrementing addresses, with MBurstLength and MReqLast, until the slave has accepted every word.

Parameters:
- AddrWidth, 8, width of MAddr and addr_in.
- DataWidth, 8, width of MData and wr_data.
- LenWidth, 4, width of len_in; burst length = len_in+1 (1..2^LenWidth words).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle burst request; sampled only in IDLE.
- addr_in  in  AddrWidth  burst base address, sampled with start.
- len_in  in  LenWidth  burst length minus one, sampled with start.
- wr_data  in  DataWidth  upstream write word.
- wr_valid  in  1  upstream word valid.
- wr_ready  out  1  word consumed this cycle (combinational).
- MCmd  out  3  3'b000 IDLE, 3'b001 WR; registered.
- MAddr  out  AddrWidth  request address; registered.
- MData  out  DataWidth  request data; registered.
- MBurstLength  out  LenWidth+1  len_in+1, held for the whole burst; registered.
- MReqLast  out  1  high with the final word of a burst; registered.
- SCmdAccept  in  1  slave accepts the current request this cycle.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - MCmd, MAddr, MData, MBurstLength, MReqLast, busy, done, and the internal remaining count all become 0.
  - Reset overrides every other input, including mid-burst; no partial-burst completion and no done pulse.
- States: IDLE, FETCH, SEND.
- IDLE:
  - wr_ready=0, MCmd=IDLE.
  - start=1 latches the following, sets busy=1 and moves to FETCH:
    - cur_addr=addr_in;
    - remaining=len_in;
    - MBurstLength=len_in+1, zero-extended.
- FETCH:
  - wr_ready=1.
  - When wr_valid=1, the following are registered and the state moves to SEND:
    - MData<=wr_data;
    - MAddr<=cur_addr;
    - MCmd<=WR;
    - MReqLast<=(remaining==0).
  - When wr_valid=0, the block waits with MCmd=IDLE.
- SEND:
  - MCmd, MAddr, MData and MReqLast are held stable until SCmdAccept=1.
  - On accept with remaining!=0:
    - cur_addr+1 (wraps modulo 2^AddrWidth);
    - remaining-1.
    - If wr_valid=1 in the same cycle: wr_ready=1, the next word is loaded directly and the state stays in SEND (back-to-back, 1 word/cycle).
    - Otherwise: MCmd<=IDLE and the state goes to FETCH.
  - On accept with remaining==0:
    - MCmd<=IDLE, MReqLast<=0, busy<=0, done<=1, state goes to IDLE.
- wr_ready is asserted only in FETCH, or in SEND with SCmdAccept=1 and remaining!=0.
  - wr_ready is never asserted in IDLE or during the final word.
- start is ignored while busy.
- start in the same cycle as done (the state is already IDLE) is accepted.
- done is high for exactly one cycle per burst.
- Minimum latency: start at edge n gives MCmd=WR visible after edge n+2, provided wr_valid is already high.
- An N-word burst with a continuously ready slave and source shows N consecutive WR cycles.

Test Plan:
- Reset, single word:
  - Stimulus: rst high 2 cycles, then low; start with addr_in=8'h10, len_in=0; wr_valid=1, wr_data=8'hA5; SCmdAccept=1.
  - Required: exactly one WR cycle with MAddr=10, MData=A5, MBurstLength=1, MReqLast=1; done pulses one cycle later; busy falls with done.
- 4-word back-to-back:
  - Stimulus: addr_in=8'h20, len_in=3; source always valid with data 1,2,3,4; SCmdAccept=1.
  - Required: 4 consecutive WR cycles, MAddr 20..23, MData 1..4, MBurstLength=4, MReqLast only on the 4th word, 4 wr_ready pulses.
- Slave stall:
  - Stimulus: same burst, SCmdAccept=0 for 3 cycles on word 2.
  - Required: MAddr=21 and MData=2 held stable for the stall; wr_ready=0 during the stall; burst completes with 4 words.
- Source stall and wrap:
  - Stimulus: addr_in=8'hFE, len_in=3; wr_valid drops 2 cycles before word 3.
  - Required: MCmd=IDLE during the gap; addresses FE, FF, 00, 01; done once.
- Busy and reset:
  - Stimulus: a start pulse mid-burst; later, rst asserted while in SEND.
  - Required: the mid-burst start has no effect; the next cycle after rst shows MCmd=0, busy=0, done=0, and no further wr_ready.

Source files
------------

// File: rtl/ocp_burst_wr_master.sv
// OCP-style burst-write initiator: latches base address and length on start, then
// streams upstream words to the slave as incrementing write requests.
module ocp_burst_wr_master #(
   parameter int unsigned AddrWidth = 8,
   parameter int unsigned DataWidth = 8,
   parameter int unsigned LenWidth  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [AddrWidth-1:0] addr_in,
   input  logic [LenWidth-1:0]  len_in,
   input  logic [DataWidth-1:0] wr_data,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   output logic [2:0]           MCmd,
   output logic [AddrWidth-1:0] MAddr,
   output logic [DataWidth-1:0] MData,
   output logic [LenWidth:0]    MBurstLength,
   output logic                 MReqLast,
   input  logic                 SCmdAccept,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned BlWidth = LenWidth + 1;
   localparam logic [2:0]  CmdIdle = 3'b000;
   localparam logic [2:0]  CmdWr   = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SEND  = 2'd2
   } state_t;

   state_t                r_state,     w_state_nxt;
   logic [2:0]            r_cmd,       w_cmd_nxt;
   logic [AddrWidth-1:0]  r_maddr,     w_maddr_nxt;
   logic [DataWidth-1:0]  r_mdata,     w_mdata_nxt;
   logic [BlWidth-1:0]    r_blen,      w_blen_nxt;
   logic                  r_last,      w_last_nxt;
   logic                  r_busy,      w_busy_nxt;
   logic                  r_done,      w_done_nxt;
   logic [AddrWidth-1:0]  r_cur_addr,  w_cur_addr_nxt;
   logic [LenWidth-1:0]   r_remaining, w_remaining_nxt;
   logic                  w_ready;
   logic [AddrWidth-1:0]  w_addr_inc;
   logic [LenWidth-1:0]   w_rem_dec;

   assign w_addr_inc = r_cur_addr + AddrWidth'(1);
   assign w_rem_dec  = r_remaining - LenWidth'(1);

   // State and registered request outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cmd       <= CmdIdle;
         r_maddr     <= '0;
         r_mdata     <= '0;
         r_blen      <= '0;
         r_last      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cur_addr  <= '0;
         r_remaining <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cmd       <= w_cmd_nxt;
         r_maddr     <= w_maddr_nxt;
         r_mdata     <= w_mdata_nxt;
         r_blen      <= w_blen_nxt;
         r_last      <= w_last_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_cur_addr  <= w_cur_addr_nxt;
         r_remaining <= w_remaining_nxt;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt     = r_state;
      w_cmd_nxt       = r_cmd;
      w_maddr_nxt     = r_maddr;
      w_mdata_nxt     = r_mdata;
      w_blen_nxt      = r_blen;
      w_last_nxt      = r_last;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;
      w_cur_addr_nxt  = r_cur_addr;
      w_remaining_nxt = r_remaining;
      w_ready         = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cmd_nxt = CmdIdle;
            if (start) begin
               w_cur_addr_nxt  = addr_in;
               w_remaining_nxt = len_in;
               w_blen_nxt      = BlWidth'(len_in) + BlWidth'(1);
               w_busy_nxt      = 1'b1;
               w_state_nxt     = S_FETCH;
            end
         end

         S_FETCH: begin
            w_ready   = 1'b1;
            w_cmd_nxt = CmdIdle;
            if (wr_valid) begin
               w_mdata_nxt = wr_data;
               w_maddr_nxt = r_cur_addr;
               w_cmd_nxt   = CmdWr;
               w_last_nxt  = (r_remaining == '0);
               w_state_nxt = S_SEND;
            end
         end

         S_SEND: begin
            if (SCmdAccept) begin
               if (r_remaining != '0) begin
                  // Accepted a non-final word: advance and optionally chain the next one
                  w_ready         = 1'b1;
                  w_cur_addr_nxt  = w_addr_inc;
                  w_remaining_nxt = w_rem_dec;
                  if (wr_valid) begin
                     w_mdata_nxt = wr_data;
                     w_maddr_nxt = w_addr_inc;
                     w_cmd_nxt   = CmdWr;
                     w_last_nxt  = (w_rem_dec == '0);
                  end else begin
                     w_cmd_nxt   = CmdIdle;
                     w_state_nxt = S_FETCH;
                  end
               end else begin
                  w_cmd_nxt   = CmdIdle;
                  w_last_nxt  = 1'b0;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_cmd_nxt   = CmdIdle;
         end
      endcase
   end

   assign wr_ready     = w_ready;
   assign MCmd         = r_cmd;
   assign MAddr        = r_maddr;
   assign MData        = r_mdata;
   assign MBurstLength = r_blen;
   assign MReqLast     = r_last;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_ocp_burst_wr_master.sv
// Directed bench for ocp_burst_wr_master: hand-computed per-cycle expectations.
module tb_ocp_burst_wr_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] addr_in;
   logic [3:0] len_in;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] MCmd;
   logic [7:0] MAddr;
   logic [7:0] MData;
   logic [4:0] MBurstLength;
   logic       MReqLast;
   logic       SCmdAccept;
   logic       busy;
   logic       done;

   int n_total = 0;
   int n_pass  = 0;

   ocp_burst_wr_master #(.AddrWidth(8), .DataWidth(8), .LenWidth(4)) dut (
      .clk(clk), .rst(rst), .start(start), .addr_in(addr_in), .len_in(len_in),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .MCmd(MCmd), .MAddr(MAddr), .MData(MData), .MBurstLength(MBurstLength),
      .MReqLast(MReqLast), .SCmdAccept(SCmdAccept), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      #0;
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic exp_req(input string tag, input logic [7:0] a, input logic [7:0] d,
                          input logic last, input logic [4:0] blen);
      chk({tag, "_cmd"},  32'(MCmd), 32'd1);
      chk({tag, "_addr"}, 32'(MAddr), 32'(a));
      chk({tag, "_data"}, 32'(MData), 32'(d));
      chk({tag, "_last"}, 32'(MReqLast), 32'(last));
      chk({tag, "_blen"}, 32'(MBurstLength), 32'(blen));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; addr_in = '0; len_in = '0;
      wr_data = '0; wr_valid = 1'b0; SCmdAccept = 1'b0;

      // Reset state
      step(); step();
      chk("rst_cmd",   32'(MCmd), 32'd0);
      chk("rst_addr",  32'(MAddr), 32'd0);
      chk("rst_data",  32'(MData), 32'd0);
      chk("rst_blen",  32'(MBurstLength), 32'd0);
      chk("rst_last",  32'(MReqLast), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);

      // Single word burst
      rst = 1'b0; start = 1'b1; addr_in = 8'h10; len_in = 4'd0;
      wr_valid = 1'b1; wr_data = 8'hA5; SCmdAccept = 1'b1;
      #1 chk("s1_ready_idle", 32'(wr_ready), 32'd0);
      step(); start = 1'b0;
      chk("s1_busy", 32'(busy), 32'd1);
      chk("s1_cmd_fetch", 32'(MCmd), 32'd0);
      chk("s1_ready_fetch", 32'(wr_ready), 32'd1);
      step();
      exp_req("s1_w0", 8'h10, 8'hA5, 1'b1, 5'd1);
      chk("s1_ready_last", 32'(wr_ready), 32'd0);
      chk("s1_done_early", 32'(done), 32'd0);
      step();
      chk("s1_cmd_end", 32'(MCmd), 32'd0);
      chk("s1_done", 32'(done), 32'd1);
      chk("s1_busy_end", 32'(busy), 32'd0);
      chk("s1_last_clr", 32'(MReqLast), 32'd0);
      step();
      chk("s1_done_pulse", 32'(done), 32'd0);

      // Four-word back-to-back burst
      start = 1'b1; addr_in = 8'h20; len_in = 4'd3; wr_data = 8'd1;
      step(); start = 1'b0;
      chk("s2_ready_fetch", 32'(wr_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         step();
         exp_req($sformatf("s2_w%0d", k), 8'(8'h20 + k), 8'(k + 1), 1'(k == 3), 5'd4);
         wr_data = 8'(k + 2);
         #1 chk($sformatf("s2_ready%0d", k), 32'(wr_ready), 32'(k < 3));
      end
      step();
      chk("s2_done", 32'(done), 32'd1);
      chk("s2_cmd_end", 32'(MCmd), 32'd0);

      // Slave stall on word 2
      start = 1'b1; addr_in = 8'h20; len_in = 4'd3; wr_data = 8'd1;
      step(); start = 1'b0;
      step();
      exp_req("s3_w0", 8'h20, 8'd1, 1'b0, 5'd4);
      wr_data = 8'd2;
      step();
      SCmdAccept = 1'b0; wr_data = 8'd3;
      for (int i = 0; i < 3; i++) begin
         exp_req($sformatf("s3_hold%0d", i), 8'h21, 8'd2, 1'b0, 5'd4);
         chk($sformatf("s3_ready_stall%0d", i), 32'(wr_ready), 32'd0);
         step();
      end
      exp_req("s3_hold3", 8'h21, 8'd2, 1'b0, 5'd4);
      SCmdAccept = 1'b1;
      #1 chk("s3_ready_resume", 32'(wr_ready), 32'd1);
      step();
      exp_req("s3_w2", 8'h22, 8'd3, 1'b0, 5'd4);
      wr_data = 8'd4;
      step();
      exp_req("s3_w3", 8'h23, 8'd4, 1'b1, 5'd4);
      step();
      chk("s3_done", 32'(done), 32'd1);

      // Source stall with address wrap
      start = 1'b1; addr_in = 8'hFE; len_in = 4'd3; wr_data = 8'd1;
      step(); start = 1'b0;
      step();
      exp_req("s4_w0", 8'hFE, 8'd1, 1'b0, 5'd4);
      wr_data = 8'd2;
      step();
      exp_req("s4_w1", 8'hFF, 8'd2, 1'b0, 5'd4);
      wr_valid = 1'b0;
      step();
      chk("s4_gap0_cmd", 32'(MCmd), 32'd0);
      chk("s4_gap0_done", 32'(done), 32'd0);
      step();
      chk("s4_gap1_cmd", 32'(MCmd), 32'd0);
      chk("s4_gap_busy", 32'(busy), 32'd1);
      wr_valid = 1'b1; wr_data = 8'd3;
      step();
      exp_req("s4_w2", 8'h00, 8'd3, 1'b0, 5'd4);
      wr_data = 8'd4;
      step();
      exp_req("s4_w3", 8'h01, 8'd4, 1'b1, 5'd4);
      step();
      chk("s4_done", 32'(done), 32'd1);
      step();
      chk("s4_done_once", 32'(done), 32'd0);

      // Mid-burst start is ignored
      start = 1'b1; addr_in = 8'h40; len_in = 4'd1; wr_data = 8'd7;
      step(); start = 1'b0;
      step();
      exp_req("s5_w0", 8'h40, 8'd7, 1'b0, 5'd2);
      start = 1'b1; addr_in = 8'h80; len_in = 4'd5; wr_data = 8'd8;
      step(); start = 1'b0;
      exp_req("s5_w1", 8'h41, 8'd8, 1'b1, 5'd2);
      step();
      chk("s5_done", 32'(done), 32'd1);
      step();
      chk("s5_idle_cmd", 32'(MCmd), 32'd0);
      chk("s5_idle_busy", 32'(busy), 32'd0);

      // Reset while in SEND
      start = 1'b1; addr_in = 8'h50; len_in = 4'd3; wr_data = 8'd9;
      step(); start = 1'b0;
      step();
      exp_req("s6_w0", 8'h50, 8'd9, 1'b0, 5'd4);
      SCmdAccept = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0; SCmdAccept = 1'b1;
      chk("s6_cmd", 32'(MCmd), 32'd0);
      chk("s6_busy", 32'(busy), 32'd0);
      chk("s6_done", 32'(done), 32'd0);
      chk("s6_blen", 32'(MBurstLength), 32'd0);
      #1 chk("s6_ready", 32'(wr_ready), 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("s6_post_cmd%0d", i), 32'(MCmd), 32'd0);
         chk($sformatf("s6_post_done%0d", i), 32'(done), 32'd0);
         chk($sformatf("s6_post_ready%0d", i), 32'(wr_ready), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
